// File: rtl/pch_pwrdn_seq_if.sv
// Trigger, rail-good and gate/status bundle between the PCH AUX power-down
// sequencer and its environment.
interface pch_pwrdn_seq_if;
  logic       FM_SLP_SUS_N;
  logic       PWRGD_P3V3_AUX;
  logic       iPchPwrFlt;
  logic       iForceOff;
  logic       PWRGD_PCH_P1V8_AUX;
  logic       PWRGD_PCH_P1V05_AUX;
  logic       oRsmrstHold_n;
  logic       oP1v8EnGate;
  logic       oPwrDnBusy;
  logic       oPwrDnDone;
  logic       oTmoP1v8;
  logic       oTmoP1v05;
  logic [2:0] ovState;

  modport master (
    output FM_SLP_SUS_N, PWRGD_P3V3_AUX, iPchPwrFlt, iForceOff,
           PWRGD_PCH_P1V8_AUX, PWRGD_PCH_P1V05_AUX,
    input  oRsmrstHold_n, oP1v8EnGate, oPwrDnBusy, oPwrDnDone,
           oTmoP1v8, oTmoP1v05, ovState
  );

  modport slave (
    input  FM_SLP_SUS_N, PWRGD_P3V3_AUX, iPchPwrFlt, iForceOff,
           PWRGD_PCH_P1V8_AUX, PWRGD_PCH_P1V05_AUX,
    output oRsmrstHold_n, oP1v8EnGate, oPwrDnBusy, oPwrDnDone,
           oTmoP1v8, oTmoP1v05, ovState
  );
endinterface

// File: rtl/pch_pwrdn_seq.sv
// Orderly PCH AUX power-down sequencer: RSMRST# first, then P1V8 enable, then rail-fall waits.
// Optional discharge hold-off state is built when PCH_PWRDN_DISCHARGE_EN is defined.
module pch_pwrdn_seq #(
  parameter int RSM_HOLD_US  = 100,
  parameter int P1V8_TMO_MS  = 20,
  parameter int P1V05_TMO_MS = 20,
  parameter int DISCHARGE_MS = 50,
  parameter int CNT_BITS     = 16
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic              i1uSCE,
  input  logic              i1mSCE,
  input  logic              iGoOutFltSt,
  pch_pwrdn_seq_if.slave    bus
);

  localparam logic [2:0] ST_OFF        = 3'd0;
  localparam logic [2:0] ST_ARMED      = 3'd1;
  localparam logic [2:0] ST_RSM_LOW    = 3'd2;
  localparam logic [2:0] ST_P1V8_OFF   = 3'd3;
  localparam logic [2:0] ST_P1V05_WAIT = 3'd4;
`ifdef PCH_PWRDN_DISCHARGE_EN
  localparam logic [2:0] ST_DISCHG     = 3'd5;
  localparam logic [2:0] ST_AFTER_V105 = ST_DISCHG;
  localparam logic [CNT_BITS-1:0] kDischg = CNT_BITS'(DISCHARGE_MS);
`else
  localparam logic [2:0] ST_AFTER_V105 = ST_OFF;
`endif

  localparam logic [CNT_BITS-1:0] kRsmHold = CNT_BITS'(RSM_HOLD_US);
  localparam logic [CNT_BITS-1:0] kP1v8Tmo = CNT_BITS'(P1V8_TMO_MS);
  localparam logic [CNT_BITS-1:0] kP1v05Tmo = CNT_BITS'(P1V05_TMO_MS);

  // Reject tick settings the shared counter cannot reach.
  generate
    if ((RSM_HOLD_US  >= (1 << CNT_BITS)) || (P1V8_TMO_MS  >= (1 << CNT_BITS)) ||
        (P1V05_TMO_MS >= (1 << CNT_BITS)) || (DISCHARGE_MS >= (1 << CNT_BITS)) ||
        (RSM_HOLD_US < 0) || (P1V8_TMO_MS < 0) || (P1V05_TMO_MS < 0) || (DISCHARGE_MS < 0))
    begin : gTickRangeErr
      $error("pch_pwrdn_seq: tick parameter does not fit in CNT_BITS");
    end
  endgenerate

  logic [2:0]          state;
  logic [2:0]          nextState;
  logic [CNT_BITS-1:0] cnt;
  logic                wTrig;
  logic                inSeq;
  logic                cntCe;
  logic                setTmoP1v8;
  logic                setTmoP1v05;
  logic                rsmrstHold_n;
  logic                p1v8EnGate;
  logic                pwrDnBusy;
  logic                pwrDnDone;
  logic                tmoP1v8;
  logic                tmoP1v05;

  assign wTrig = !bus.FM_SLP_SUS_N | !bus.PWRGD_P3V3_AUX | bus.iPchPwrFlt | bus.iForceOff;
  assign inSeq = (state != ST_OFF) && (state != ST_ARMED);

  always_comb begin
    nextState    = state;
    cntCe        = 1'b0;
    setTmoP1v8   = 1'b0;
    setTmoP1v05  = 1'b0;
    case (state)
      ST_OFF: begin
        if (!wTrig) nextState = ST_ARMED;
      end
      ST_ARMED: begin
        if (wTrig) nextState = ST_RSM_LOW;
      end
      ST_RSM_LOW: begin
        cntCe = i1uSCE;
        if (cnt == kRsmHold) nextState = ST_P1V8_OFF;
      end
      ST_P1V8_OFF: begin
        cntCe = i1mSCE;
        if (!bus.PWRGD_PCH_P1V8_AUX) begin
          nextState = ST_P1V05_WAIT;
        end else if (cnt == kP1v8Tmo) begin
          setTmoP1v8 = 1'b1;
          nextState  = ST_P1V05_WAIT;
        end
      end
      ST_P1V05_WAIT: begin
        cntCe = i1mSCE;
        if (!bus.PWRGD_PCH_P1V05_AUX) begin
          nextState = ST_AFTER_V105;
        end else if (cnt == kP1v05Tmo) begin
          setTmoP1v05 = 1'b1;
          nextState   = ST_AFTER_V105;
        end
      end
`ifdef PCH_PWRDN_DISCHARGE_EN
      ST_DISCHG: begin
        cntCe = i1mSCE;
        if (cnt == kDischg) nextState = ST_OFF;
      end
`endif
      default: nextState = ST_OFF;
    endcase
    // Losing P3V3 AUX mid-sequence abandons the waits without flagging a timeout.
    if (inSeq && !bus.PWRGD_P3V3_AUX) begin
      nextState   = ST_OFF;
      setTmoP1v8  = 1'b0;
      setTmoP1v05 = 1'b0;
    end
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state        <= ST_OFF;
      cnt          <= '0;
      rsmrstHold_n <= 1'b0;
      p1v8EnGate   <= 1'b0;
      pwrDnBusy    <= 1'b0;
      pwrDnDone    <= 1'b0;
      tmoP1v8      <= 1'b0;
      tmoP1v05     <= 1'b0;
    end else begin
      state <= nextState;
      if (nextState != state)          cnt <= '0;
      else if (cntCe && (cnt != '1))   cnt <= cnt + 1'b1;

      // Outputs are decoded from the next state so they move with the state register.
      rsmrstHold_n <= (nextState == ST_ARMED);
      p1v8EnGate   <= (nextState == ST_ARMED) || (nextState == ST_RSM_LOW);
      pwrDnBusy    <= (nextState != ST_OFF) && (nextState != ST_ARMED);
      pwrDnDone    <= (nextState == ST_OFF) && inSeq;

      if (iGoOutFltSt) begin
        tmoP1v8  <= 1'b0;
        tmoP1v05 <= 1'b0;
      end else begin
        if (setTmoP1v8)  tmoP1v8  <= 1'b1;
        if (setTmoP1v05) tmoP1v05 <= 1'b1;
      end
    end
  end

  assign bus.oRsmrstHold_n = rsmrstHold_n;
  assign bus.oP1v8EnGate   = p1v8EnGate;
  assign bus.oPwrDnBusy    = pwrDnBusy;
  assign bus.oPwrDnDone    = pwrDnDone;
  assign bus.oTmoP1v8      = tmoP1v8;
  assign bus.oTmoP1v05     = tmoP1v05;
  assign bus.ovState       = state;

endmodule

// File: tb/tb_pch_pwrdn_seq.sv
// Scoreboard bench for pch_pwrdn_seq: every state change is matched against an expected
// entry queued when the stimulus that causes it is driven.
module tb_pch_pwrdn_seq;
  localparam int RSM_HOLD_US  = 100;
  localparam int P1V8_TMO_MS  = 20;
  localparam int P1V05_TMO_MS = 20;
  localparam int DISCHARGE_MS = 50;

  logic iClk = 1'b0;
  logic iRst_n;
  logic i1uSCE;
  logic i1mSCE;
  logic iGoOutFltSt;

  pch_pwrdn_seq_if bus ();

  pch_pwrdn_seq #(
    .RSM_HOLD_US (RSM_HOLD_US),
    .P1V8_TMO_MS (P1V8_TMO_MS),
    .P1V05_TMO_MS(P1V05_TMO_MS),
    .DISCHARGE_MS(DISCHARGE_MS),
    .CNT_BITS    (16)
  ) dut (
    .iClk       (iClk),
    .iRst_n     (iRst_n),
    .i1uSCE     (i1uSCE),
    .i1mSCE     (i1mSCE),
    .iGoOutFltSt(iGoOutFltSt),
    .bus        (bus)
  );

  always #5 iClk = ~iClk;

  // outs = {oRsmrstHold_n, oP1v8EnGate, oPwrDnBusy, oPwrDnDone}; tmo = {oTmoP1v8, oTmoP1v05}
  typedef struct packed {
    logic [2:0] st;
    logic [3:0] outs;
    logic [1:0] tmo;
  } exp_t;

  exp_t sbQ[$];
  int   nVec = 0;
  int   nMis = 0;
  logic monEn = 1'b0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nVec++;
    if (got !== exp) begin
      nMis++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic pushExp(input logic [2:0] st, input logic [3:0] outs, input logic [1:0] tmo);
    exp_t e;
    e.st = st; e.outs = outs; e.tmo = tmo;
    sbQ.push_back(e);
  endtask

  task automatic pulseUs(input int n);
    repeat (n) begin
      i1uSCE = 1'b1; @(negedge iClk);
      i1uSCE = 1'b0; @(negedge iClk);
    end
  endtask

  task automatic pulseMs(input int n);
    repeat (n) begin
      i1mSCE = 1'b1; @(negedge iClk);
      i1mSCE = 1'b0; @(negedge iClk);
    end
  endtask

  task automatic waitState(input logic [2:0] st, input int budget);
    for (int i = 0; i < budget && bus.ovState !== st; i++) @(negedge iClk);
    checkVal("waitState", 32'(bus.ovState), 32'(st));
  endtask

  // P1V05 wait exit: mode 0 = rail falls now, 1 = final timeout tick, 2 = rail already low.
  task automatic rail105Exit(input logic [1:0] tmo, input int mode);
`ifdef PCH_PWRDN_DISCHARGE_EN
    pushExp(3'd5, 4'b0010, tmo);
`else
    pushExp(3'd0, 4'b0001, tmo);
`endif
    if (mode == 0)      bus.PWRGD_PCH_P1V05_AUX = 1'b0;
    else if (mode == 1) pulseMs(1);
`ifdef PCH_PWRDN_DISCHARGE_EN
    waitState(3'd5, 20);
    pulseMs(DISCHARGE_MS - 1);
    checkVal("dischgHold", 32'(bus.ovState), 32'd5);
    checkVal("dischgGates", 32'({bus.oRsmrstHold_n, bus.oP1v8EnGate}), 32'd0);
    pushExp(3'd0, 4'b0001, tmo);
    pulseMs(1);
`endif
    waitState(3'd0, 20);
  endtask

  // Scoreboard monitor
  initial begin
    logic [2:0] prevSt;
    exp_t e;
    wait (monEn);
    prevSt = 3'd0;
    forever begin
      @(negedge iClk);
      if (bus.ovState !== prevSt) begin
        prevSt = bus.ovState;
        checkVal("sbHasEntry", 32'(sbQ.size() > 0), 32'd1);
        if (sbQ.size() > 0) begin
          e = sbQ.pop_front();
          checkVal("sbState", 32'(bus.ovState), 32'(e.st));
          checkVal("sbOuts", 32'({bus.oRsmrstHold_n, bus.oP1v8EnGate, bus.oPwrDnBusy, bus.oPwrDnDone}),
                   32'(e.outs));
          checkVal("sbTmo", 32'({bus.oTmoP1v8, bus.oTmoP1v05}), 32'(e.tmo));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    iRst_n = 1'b0; i1uSCE = 1'b0; i1mSCE = 1'b0; iGoOutFltSt = 1'b0;
    bus.FM_SLP_SUS_N = 1'b1; bus.PWRGD_P3V3_AUX = 1'b1;
    bus.iPchPwrFlt = 1'b0;   bus.iForceOff = 1'b0;
    bus.PWRGD_PCH_P1V8_AUX = 1'b1; bus.PWRGD_PCH_P1V05_AUX = 1'b1;
    repeat (3) @(negedge iClk);
    checkVal("rstState", 32'(bus.ovState), 32'd0);
    checkVal("rstOuts", 32'({bus.oRsmrstHold_n, bus.oP1v8EnGate, bus.oPwrDnBusy, bus.oPwrDnDone}), 32'd0);
    checkVal("rstTmo", 32'({bus.oTmoP1v8, bus.oTmoP1v05}), 32'd0);
    monEn = 1'b1;

    // Reset release with everything good: arm one cycle later.
    pushExp(3'd1, 4'b1100, 2'b00);
    iRst_n = 1'b1;
    @(negedge iClk);
    checkVal("armIn1", 32'(bus.ovState), 32'd1);

    // Normal SLP_SUS# shutdown.
    pushExp(3'd2, 4'b0110, 2'b00);
    bus.FM_SLP_SUS_N = 1'b0;
    @(negedge iClk);
    checkVal("rsmNext", 32'(bus.oRsmrstHold_n), 32'd0);
    pulseUs(RSM_HOLD_US - 1);
    checkVal("rsmHold99", 32'(bus.ovState), 32'd2);
    pushExp(3'd3, 4'b0010, 2'b00);
    pulseUs(1);
    waitState(3'd3, 5);
    pulseMs(2);
    pushExp(3'd4, 4'b0010, 2'b00);
    bus.PWRGD_PCH_P1V8_AUX = 1'b0;
    waitState(3'd4, 5);
    pulseMs(2);
    rail105Exit(2'b00, 0);
    @(negedge iClk);
    checkVal("doneOneCyc", 32'(bus.oPwrDnDone), 32'd0);
    checkVal("offWhileTrig", 32'(bus.ovState), 32'd0);
    pushExp(3'd1, 4'b1100, 2'b00);
    bus.FM_SLP_SUS_N = 1'b1; bus.PWRGD_PCH_P1V8_AUX = 1'b1; bus.PWRGD_PCH_P1V05_AUX = 1'b1;
    waitState(3'd1, 5);

    // PCH fault with both rails stuck high: both timeouts, flags survive re-arm.
    pushExp(3'd2, 4'b0110, 2'b00);
    bus.iPchPwrFlt = 1'b1;
    waitState(3'd2, 5);
    pushExp(3'd3, 4'b0010, 2'b00);
    pulseUs(RSM_HOLD_US);
    waitState(3'd3, 5);
    pulseMs(P1V8_TMO_MS - 1);
    checkVal("p1v8Tmo19", 32'({bus.ovState, bus.oTmoP1v8}), 32'({3'd3, 1'b0}));
    pushExp(3'd4, 4'b0010, 2'b10);
    pulseMs(1);
    waitState(3'd4, 5);
    pulseMs(P1V05_TMO_MS - 1);
    checkVal("p1v05Tmo19", 32'(bus.ovState), 32'd4);
    rail105Exit(2'b11, 1);
    pushExp(3'd1, 4'b1100, 2'b11);
    bus.iPchPwrFlt = 1'b0;
    waitState(3'd1, 5);
    iGoOutFltSt = 1'b1; @(negedge iClk); iGoOutFltSt = 1'b0;
    checkVal("fltClr", 32'({bus.oTmoP1v8, bus.oTmoP1v05}), 32'd0);
    checkVal("fltClrSt", 32'(bus.ovState), 32'd1);

    // One-cycle force-off, then P3V3 AUX lost in the P1V8 wait.
    pushExp(3'd2, 4'b0110, 2'b00);
    bus.iForceOff = 1'b1; @(negedge iClk); bus.iForceOff = 1'b0;
    waitState(3'd2, 5);
    pushExp(3'd3, 4'b0010, 2'b00);
    pulseUs(RSM_HOLD_US);
    waitState(3'd3, 5);
    pulseMs(5);
    pushExp(3'd0, 4'b0001, 2'b00);
    bus.PWRGD_P3V3_AUX = 1'b0;
    @(negedge iClk);
    checkVal("abortNext", 32'(bus.ovState), 32'd0);
    @(negedge iClk);
    checkVal("noArmP3v3Low", 32'(bus.ovState), 32'd0);
    pushExp(3'd1, 4'b1100, 2'b00);
    bus.PWRGD_P3V3_AUX = 1'b1;
    @(negedge iClk);
    checkVal("rearm1", 32'(bus.ovState), 32'd1);

    // Trigger drops mid-sequence; P1V8 fall coincides with timeout; P1V05 already low.
    pushExp(3'd2, 4'b0110, 2'b00);
    bus.FM_SLP_SUS_N = 1'b0; @(negedge iClk); bus.FM_SLP_SUS_N = 1'b1;
    pushExp(3'd3, 4'b0010, 2'b00);
    pulseUs(RSM_HOLD_US);
    waitState(3'd3, 5);
    pulseMs(P1V8_TMO_MS - 1);
    i1mSCE = 1'b1; @(negedge iClk); i1mSCE = 1'b0;
    pushExp(3'd4, 4'b0010, 2'b00);
    bus.PWRGD_PCH_P1V8_AUX = 1'b0; bus.PWRGD_PCH_P1V05_AUX = 1'b0;
    waitState(3'd4, 5);
    rail105Exit(2'b00, 2);
    pushExp(3'd1, 4'b1100, 2'b00);
    bus.PWRGD_PCH_P1V8_AUX = 1'b1; bus.PWRGD_PCH_P1V05_AUX = 1'b1;
    waitState(3'd1, 5);

    // Flag clear wins over a same-cycle timeout; then reset mid-sequence.
    pushExp(3'd2, 4'b0110, 2'b00);
    bus.FM_SLP_SUS_N = 1'b0;
    pushExp(3'd3, 4'b0010, 2'b00);
    pulseUs(RSM_HOLD_US + 1);
    waitState(3'd3, 5);
    pulseMs(P1V8_TMO_MS - 1);
    i1mSCE = 1'b1; @(negedge iClk); i1mSCE = 1'b0;
    pushExp(3'd4, 4'b0010, 2'b00);
    iGoOutFltSt = 1'b1; @(negedge iClk); iGoOutFltSt = 1'b0;
    waitState(3'd4, 5);
    pulseMs(3);
    pushExp(3'd0, 4'b0000, 2'b00);
    iRst_n = 1'b0;
    @(negedge iClk);
    waitState(3'd0, 5);
    @(negedge iClk);
    checkVal("rstMidGates", 32'({bus.oRsmrstHold_n, bus.oP1v8EnGate}), 32'd0);
    pushExp(3'd1, 4'b1100, 2'b00);
    bus.FM_SLP_SUS_N = 1'b1;
    iRst_n = 1'b1;
    waitState(3'd1, 5);

    repeat (2) @(negedge iClk);
    checkVal("sbDrained", 32'(sbQ.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end
endmodule

// File: doc/pch_pwrdn_seq.md
Name: pch_pwrdn_seq

Overview:
Orderly power-down sequencer for the PCH AUX domain. It is the shutdown counterpart of the PCH power-up sequencer.
- On a shutdown trigger it first asserts RSMRST#, then removes the P1V8 AUX enable, then waits for each PCH rail's PWRGD to drop, with a per-rail timeout.
- Outputs are AND-gates applied downstream onto the up-sequencer's RST_RSMRST_N and FM_PCH_P1V8_AUX_EN.
- Re-arm is permitted only after a completed shutdown.

Parameters:
RSM_HOLD_US, 100, 1 uS ticks RSMRST# is held low before P1V8 enable is removed (0 = single cycle)
P1V8_TMO_MS, 20, 1 mS ticks allowed for PWRGD_PCH_P1V8_AUX to fall
P1V05_TMO_MS, 20, 1 mS ticks allowed for PWRGD_PCH_P1V05_AUX to fall
DISCHARGE_MS, 50, 1 mS ticks of discharge hold-off (only with PCH_PWRDN_DISCHARGE_EN)
CNT_BITS, 16, width of the shared delay/timeout counter; all tick parameters must fit

Ports:
iClk  in  1  system clock
iRst_n  in  1  synchronous active-low reset
i1uSCE  in  1  1 uS clock enable
i1mSCE  in  1  1 mS clock enable
iGoOutFltSt  in  1  clears latched timeout flags
FM_SLP_SUS_N  in  1  SLP_SUS#; low = shutdown trigger
PWRGD_P3V3_AUX  in  1  P3V3 AUX PWRGD; low = trigger / abort
iPchPwrFlt  in  1  PCH VR fault from up-sequencer; high = trigger
iForceOff  in  1  BMC-requested PCH off; high = trigger
PWRGD_PCH_P1V8_AUX  in  1  PCH P1V8 PWRGD
PWRGD_PCH_P1V05_AUX  in  1  PCH P1V05 PWRGD
oRsmrstHold_n  out  1  ANDed onto RST_RSMRST_N; low forces RSMRST# asserted
oP1v8EnGate  out  1  ANDed onto FM_PCH_P1V8_AUX_EN
oPwrDnBusy  out  1  high while a shutdown is in progress
oPwrDnDone  out  1  one-cycle pulse when the sequence reaches ST_OFF
oTmoP1v8  out  1  latched P1V8 fall timeout
oTmoP1v05  out  1  latched P1V05 fall timeout
ovState  out  3  state encoding, for debug/SMBus visibility

Behaviour:
- Trigger (combinational): wTrig = !FM_SLP_SUS_N | !PWRGD_P3V3_AUX | iPchPwrFlt | iForceOff.
- Reset values:
  - state ST_OFF (3'd0)
  - oRsmrstHold_n = 0, oP1v8EnGate = 0, oPwrDnBusy = 0, oPwrDnDone = 0
  - oTmoP1v8 = 0, oTmoP1v05 = 0
  - counter = 0
- All outputs are registered. An output change occurs in the same cycle the state register updates.
- Single counter. It clears on every state entry and increments on the CE relevant to the current state.
- State ST_OFF (0): gates low, busy = 0.
  - If !wTrig, go to ST_ARMED on the next cycle.
- State ST_ARMED (1): oRsmrstHold_n = 1, oP1v8EnGate = 1, busy = 0.
  - If wTrig is sampled at cycle N, go to ST_RSM_LOW at N+1. At N+1, oRsmrstHold_n = 0 and busy = 1.
- State ST_RSM_LOW (2): RSMRST# held, enable gate still 1.
  - Counts i1uSCE. When count == RSM_HOLD_US, go to ST_P1V8_OFF.
  - RSM_HOLD_US = 0 exits after 1 cycle.
- State ST_P1V8_OFF (3): oP1v8EnGate = 0. Counts i1mSCE.
  - If !PWRGD_PCH_P1V8_AUX, go to ST_P1V05_WAIT.
  - Else if count == P1V8_TMO_MS, set oTmoP1v8 and go to ST_P1V05_WAIT (sequence continues).
- State ST_P1V05_WAIT (4): counts i1mSCE.
  - If !PWRGD_PCH_P1V05_AUX, go to ST_DISCHG (macro on) or ST_OFF.
  - On timeout (count == P1V05_TMO_MS), set oTmoP1v05 and take the same exit.
- State ST_DISCHG (5, macro only): counts i1mSCE to DISCHARGE_MS, then goes to ST_OFF.
- oPwrDnDone pulses 1 cycle on every entry to ST_OFF from states 2–5.
- Boundary conditions:
  - Trigger deasserting mid-sequence is ignored; the sequence always completes to ST_OFF. Re-arm happens only from ST_OFF.
  - PWRGD_P3V3_AUX low while in states 2–5: go to ST_OFF on the next cycle. No timeout is flagged and oPwrDnDone still pulses.
  - PWRGD already low on entry to a wait state: exit after 1 cycle.
  - PWRGD fall and timeout in the same cycle: the fall wins; no flag is set.
  - iGoOutFltSt clears both timeout flags and has priority over a same-cycle set. It does not alter the state.
  - Timeout flags survive re-arm. Only reset or iGoOutFltSt clears them.
  - Reset mid-sequence: ST_OFF with gates low. RSMRST# therefore stays asserted until re-arm.
  - Counter saturates and never wraps.

Optional Feature:
- Macro: PCH_PWRDN_DISCHARGE_EN.
- Defined: ST_DISCHG is present. Re-enable is blocked for DISCHARGE_MS after P1V05 falls or times out.
- Undefined: state 5 does not exist, ST_P1V05_WAIT exits directly to ST_OFF, and the DISCHARGE_MS parameter is unused.

Test Plan:
- Reset release with all rails good and SLP_SUS_N = 1: ST_OFF → ST_ARMED in 1 cycle; both gates go to 1.
- SLP_SUS_N 1→0 at cycle N: oRsmrstHold_n = 0 at N+1; oP1v8EnGate = 0 after exactly 100 i1uSCE pulses; P1V8 then P1V05 PWRGD drop 2 mS later → oPwrDnDone pulses, no timeout flags.
- P1V8 PWRGD stuck high: oTmoP1v8 = 1 after 20 i1mSCE pulses; sequence proceeds to the P1V05 wait; iGoOutFltSt pulse clears the flag.
- P3V3 AUX drops during ST_P1V8_OFF: next cycle ovState = 0, gates low, no timeout flag, oPwrDnDone pulses.
- iForceOff pulses for 1 cycle in ST_ARMED: the full sequence still completes; re-arm occurs 1 cycle after ST_OFF once all triggers are clear.
- Macro defined, DISCHARGE_MS = 50: ST_OFF is reached 50 i1mSCE pulses after P1V05 falls; gates stay low throughout.
